regfile_mp: RTL and testbench

Multi-port, parametrised successor of the CPU integer register file. It provides NUM_RD combinational read ports, NUM_WR synchronous write ports and optional same-cycle write-to-read bypass. A per-register busy scoreboard tracks pending writebacks so pipelined or dual-issue datapaths can detect hazards. It sits in the decode stage; write ports come from writeback and allocation comes from issue.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, register-index types and well-known register numbers for the
// multi-port integer register file.
package regfile_pkg;
  localparam int DEFAULT_ADDRESS_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_NUM_RD        = 2;
  localparam int DEFAULT_NUM_WR        = 1;

  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0]    reg_data_t;

  localparam int ZERO_REG = 0;
  localparam int A0_REG   = 10;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending writebacks: set by issue allocation,
// cleared by writeback, looked up per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int NUM_RD        = DEFAULT_NUM_RD,
  parameter int NUM_WR        = DEFAULT_NUM_WR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] raddr,
  input  logic [NUM_WR-1:0]               we,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0] waddr,
  input  logic                            alloc_valid,
  input  logic [ADDRESS_WIDTH-1:0]        alloc_addr,
  output logic [NUM_RD-1:0]               port_busy,
  output logic                            busy_any
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] busy;

  // The allocation is applied after the clears so a same-edge set wins:
  // the new producer supersedes the writeback that is retiring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j]) busy[waddr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= 1'b0;
      end
      if (alloc_valid && (alloc_addr != '0)) busy[alloc_addr] <= 1'b1;
    end
  end

  always_comb begin
    port_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      port_busy[i] = busy[raddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
    end
  end

  assign busy_any = |busy;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// pending-writeback scoreboard for hazard detection in decode.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int NUM_RD        = DEFAULT_NUM_RD,
  parameter int NUM_WR        = DEFAULT_NUM_WR,
  parameter int BYPASS        = 1,
  parameter int TAP_INDEX     = A0_REG
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rdata,
  output logic [NUM_RD-1:0]               rbusy,
  input  logic [NUM_WR-1:0]               we,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wdata,
  input  logic                            alloc_valid,
  input  logic [ADDRESS_WIDTH-1:0]        alloc_addr,
  output logic [DATA_WIDTH-1:0]           tap_data,
  output logic                            busy_any
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] TAP_ADDR = ADDRESS_WIDTH'(TAP_INDEX);

  if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end
  if ((NUM_WR < 1) || (NUM_WR > 2)) begin : g_bad_num_wr
    $error("regfile_mp: NUM_WR must be in 1..2");
  end

  logic [DATA_WIDTH-1:0]    regs [DEPTH];
  logic [NUM_RD-1:0]        sb_busy;
  logic [NUM_RD-1:0]        fwd;
  logic [ADDRESS_WIDTH-1:0] ra;

  // Later ports are applied last, so the highest-index writer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (waddr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
          regs[waddr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    fwd   = '0;
    ra    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (ra != '0) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && (waddr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ra)) begin
              rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
              fwd[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // alloc_valid has no ready: an allocation is accepted on every edge it is
  // presented, and writeback ports are likewise always accepted.
  regfile_scoreboard #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_RD       (NUM_RD),
    .NUM_WR       (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .we         (we),
    .waddr      (waddr),
    .alloc_valid(alloc_valid),
    .alloc_addr (alloc_addr),
    .port_busy  (sb_busy),
    .busy_any   (busy_any)
  );

  // A forwarded operand is no longer a hazard, so its busy flag is hidden.
  assign rbusy    = sb_busy & ~fwd;
  assign tap_data = (TAP_INDEX == ZERO_REG) ? '0 : regs[TAP_ADDR];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomised checks of regfile_mp: a bypassing dual-write
// instance and a non-bypassing single-write instance.
module tb_regfile_mp;
  import regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // bypassing, 2 read / 2 write
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic [31:0] tap_data;
  logic        busy_any;

  // non-bypassing, 1 read / 1 write
  logic [4:0]  nb_raddr;
  logic [31:0] nb_rdata;
  logic [0:0]  nb_rbusy;
  logic [0:0]  nb_we;
  logic [4:0]  nb_waddr;
  logic [31:0] nb_wdata;
  logic        nb_alloc_valid;
  logic [4:0]  nb_alloc_addr;
  logic [31:0] nb_tap;
  logic        nb_busy_any;

  regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .tap_data(tap_data), .busy_any(busy_any)
  );

  regfile_mp #(.NUM_RD(1), .NUM_WR(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .raddr(nb_raddr), .rdata(nb_rdata), .rbusy(nb_rbusy),
    .we(nb_we), .waddr(nb_waddr), .wdata(nb_wdata), .alloc_valid(nb_alloc_valid),
    .alloc_addr(nb_alloc_addr), .tap_data(nb_tap), .busy_any(nb_busy_any)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed %h expected none queued", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    raddr = '0; we = '0; waddr = '0; wdata = '0;
    alloc_valid = 1'b0; alloc_addr = '0;
    nb_raddr = '0; nb_we = '0; nb_waddr = '0; nb_wdata = '0;
    nb_alloc_valid = 1'b0; nb_alloc_addr = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    we[port] = 1'b1;
    waddr[port*5 +: 5] = a;
    wdata[port*32 +: 32] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;

    idle();
    #2;
    expect_val("reset_rdata0", 32'h0);     check(rdata[31:0]);
    expect_val("reset_rbusy", 32'h0);      check(32'(rbusy));
    expect_val("reset_tap", 32'h0);        check(tap_data);
    expect_val("reset_busy_any", 32'h0);   check(32'(busy_any));
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-operation wipes storage and scoreboard asynchronously
    wr(0, 5'd5, 32'hDEADBEEF);
    alloc_valid = 1'b1; alloc_addr = 5'd6;
    step();
    idle();
    raddr[4:0] = 5'd5;
    #1;
    expect_val("pre_reset_x5", 32'hDEADBEEF); check(rdata[31:0]);
    expect_val("pre_reset_busy_any", 32'h1);  check(32'(busy_any));
    rst = 1'b1;
    #1;
    expect_val("async_reset_x5", 32'h0);       check(rdata[31:0]);
    expect_val("async_reset_tap", 32'h0);      check(tap_data);
    expect_val("async_reset_busy_any", 32'h0); check(32'(busy_any));
    rst = 1'b0;
    step();

    // Bypass on write to x7
    wr(0, 5'd7, 32'h1234);
    raddr[4:0] = 5'd7;
    #1;
    expect_val("bypass_same_cycle", 32'h1234); check(rdata[31:0]);
    step();
    idle();
    raddr[4:0] = 5'd7;
    #1;
    expect_val("bypass_after_edge", 32'h1234); check(rdata[31:0]);
    step();

    // x0 stays zero
    wr(0, 5'd0, 32'hFFFF);
    raddr[4:0] = 5'd0;
    #1;
    expect_val("x0_bypass", 32'h0); check(rdata[31:0]);
    step();
    idle();
    #1;
    expect_val("x0_stored", 32'h0); check(rdata[31:0]);
    step();

    // Dual-port conflict: port 1 wins
    wr(0, 5'd9, 32'hAAAA);
    wr(1, 5'd9, 32'h5555);
    raddr = {5'd9, 5'd9};
    #1;
    expect_val("conflict_bypass_p0", 32'h5555); check(rdata[31:0]);
    expect_val("conflict_bypass_p1", 32'h5555); check(rdata[63:32]);
    step();
    idle();
    raddr[4:0] = 5'd9;
    #1;
    expect_val("conflict_stored", 32'h5555); check(rdata[31:0]);
    step();

    // Scoreboard: allocate x3
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    raddr = {5'd4, 5'd3};
    #1;
    expect_val("alloc_not_yet_busy", 32'h0); check(32'(rbusy[0]));
    step();
    idle();
    raddr = {5'd4, 5'd3};
    #1;
    expect_val("alloc_busy", 32'h1);       check(32'(rbusy[0]));
    expect_val("alloc_other_idle", 32'h0); check(32'(rbusy[1]));
    expect_val("alloc_busy_any", 32'h1);   check(32'(busy_any));
    // writeback of x3 while reading it: forwarded, so not busy
    wr(0, 5'd3, 32'h33);
    #1;
    expect_val("wb_masked_rbusy", 32'h0); check(32'(rbusy[0]));
    expect_val("wb_forward_data", 32'h33); check(rdata[31:0]);
    expect_val("wb_unmasked_other", 32'h0); check(32'(rbusy[1]));
    step();
    idle();
    raddr[4:0] = 5'd3;
    #1;
    expect_val("wb_cleared", 32'h0);          check(32'(rbusy[0]));
    expect_val("wb_cleared_busy_any", 32'h0); check(32'(busy_any));
    // allocate and write x3 in one cycle: set wins
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    wr(0, 5'd3, 32'h44);
    step();
    idle();
    raddr[4:0] = 5'd3;
    #1;
    expect_val("set_wins_rbusy", 32'h1);    check(32'(rbusy[0]));
    expect_val("set_wins_busy_any", 32'h1); check(32'(busy_any));
    expect_val("set_wins_data", 32'h44);    check(rdata[31:0]);
    // clear x3 through write port 1
    wr(1, 5'd3, 32'h45);
    step();
    idle();
    #1;
    expect_val("port1_clear", 32'h0); check(32'(busy_any));
    // allocating x0 is ignored
    alloc_valid = 1'b1; alloc_addr = 5'd0;
    step();
    idle();
    #1;
    expect_val("alloc_x0_ignored", 32'h0); check(32'(busy_any));
    expect_val("alloc_x0_rbusy", 32'h0);   check(32'(rbusy[0]));

    // Random writes read back on port 1 (x10 excluded for the tap test)
    for (int n = 0; n < 8; n++) begin
      ra = 5'($urandom_range(11, 31));
      rd = $urandom;
      wr(0, ra, rd);
      expect_val("random_readback", rd);
      step();
      idle();
      raddr[9:5] = ra;
      #1;
      check(rdata[63:32]);
    end
    step();

    // Tap tracks stored x10 only
    wr(0, 5'd10, 32'hCAFEF00D);
    #1;
    expect_val("tap_no_bypass", 32'h0); check(tap_data);
    step();
    idle();
    #1;
    expect_val("tap_updated", 32'hCAFEF00D); check(tap_data);
    wr(1, 5'd16, 32'h1);
    step();
    idle();
    raddr[9:5] = 5'd16;
    #1;
    expect_val("tap_unchanged", 32'hCAFEF00D); check(tap_data);
    expect_val("x16_stored", 32'h1);           check(rdata[63:32]);
    step();

    // Non-bypassing instance
    nb_alloc_valid = 1'b1; nb_alloc_addr = 5'd4;
    step();
    idle();
    nb_we = 1'b1; nb_waddr = 5'd4; nb_wdata = 32'h77;
    nb_raddr = 5'd4;
    #1;
    expect_val("nb_write_cycle_data", 32'h0); check(nb_rdata);
    expect_val("nb_rbusy_unmasked", 32'h1);   check(32'(nb_rbusy));
    step();
    idle();
    nb_raddr = 5'd4;
    #1;
    expect_val("nb_next_cycle_data", 32'h77); check(nb_rdata);
    expect_val("nb_busy_cleared", 32'h0);     check(32'(nb_busy_any));

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d queued expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no completion expected finish before 50000");
    $fatal(1, "timeout");
  end
endmodule
